countdown_timer_8bit: RTL and testbench

COUNTDOWN_TIMER_8BIT -- requirements
Module: countdown_timer_8bit

---
 rtl/countdown_timer_8bit.sv | 111 +++++++++++
 tb/tb_countdown_timer_8bit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer_8bit.sv
// Programmable down-counter with start/stop/resume, optional auto-reload and
// a registered terminal-tick pulse.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a command; count held (fresh load or paused)
// RUN     | counting down on enabled ticks
// EXPIRED | reached zero without auto-reload; waits for start or load
module countdown_timer_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_auto_reload,
  output logic [WIDTH-1:0] o_count,
  output logic             o_busy,
  output logic             o_expired,
  output logic             o_done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_EXPIRED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  // Stop outranks start in every state, so a stop in IDLE/EXPIRED masks a start.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;

    if (i_load) begin
      count_d  = i_load_value;
      reload_d = i_load_value;
      state_d  = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!i_stop && i_start) begin
            if (count_q != '0) begin
              state_d = S_RUN;
            end else begin
              state_d = S_EXPIRED;
              done_d  = 1'b1;
            end
          end
        end
        S_RUN: begin
          if (i_stop) begin
            state_d = S_IDLE;
          end else if (i_en) begin
            if (count_q > WIDTH'(1)) begin
              count_d = count_q - WIDTH'(1);
            end else if (count_q == WIDTH'(1)) begin
              done_d = 1'b1;
              if (i_auto_reload) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = S_EXPIRED;
              end
            end
          end
        end
        S_EXPIRED: begin
          if (!i_stop && i_start) begin
            if (reload_q != '0) begin
              count_d = reload_q;
              state_d = S_RUN;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign o_count   = count_q;
  assign o_busy    = (state_q == S_RUN);
  assign o_expired = (state_q == S_EXPIRED);
  assign o_done    = done_q;

endmodule

// File: tb/tb_countdown_timer_8bit.sv
// Scoreboard bench: stimulus pushes hand-computed expected outputs, a monitor
// pops and compares them after each rising edge (or on an async-reset kick).
module tb_countdown_timer_8bit;

  localparam int W = 8;

  logic         i_clk = 1'b0;
  logic         i_reset_n = 1'b0;
  logic         i_en = 1'b0;
  logic         i_load = 1'b0;
  logic [W-1:0] i_load_value = '0;
  logic         i_start = 1'b0;
  logic         i_stop = 1'b0;
  logic         i_auto_reload = 1'b0;
  logic [W-1:0] o_count;
  logic         o_busy;
  logic         o_expired;
  logic         o_done;

  countdown_timer_8bit #(.WIDTH(W)) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_en         (i_en),
    .i_load       (i_load),
    .i_load_value (i_load_value),
    .i_start      (i_start),
    .i_stop       (i_stop),
    .i_auto_reload(i_auto_reload),
    .o_count      (o_count),
    .o_busy       (o_busy),
    .o_expired    (o_expired),
    .o_done       (o_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string        name;
    logic [W-1:0] count;
    logic         busy;
    logic         expired;
    logic         done;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  event mon_kick;

  // Monitor: compares the oldest expectation once outputs have settled.
  initial begin
    exp_t e;
    forever begin
      @(posedge i_clk or mon_kick);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        if ({o_count, o_busy, o_expired, o_done} !== {e.count, e.busy, e.expired, e.done}) begin
          n_bad++;
          $display("FAIL %s: got count=%0d busy=%b expired=%b done=%b, want count=%0d busy=%b expired=%b done=%b",
                   e.name, o_count, o_busy, o_expired, o_done, e.count, e.busy, e.expired, e.done);
        end
      end
    end
  end

  function automatic void expect_out(string name, int c, bit b, bit x, bit d);
    exp_t e;
    e.name    = name;
    e.count   = W'(c);
    e.busy    = b;
    e.expired = x;
    e.done    = d;
    q.push_back(e);
  endfunction

  // One clock: drive commands at the falling edge, expectation is for the next rise.
  task automatic cyc(string name, bit ld, int lv, bit st, bit sp, bit en, bit ar,
                     int c, bit b, bit x, bit d);
    @(negedge i_clk);
    i_load        = ld;
    i_load_value  = W'(lv);
    i_start       = st;
    i_stop        = sp;
    i_en          = en;
    i_auto_reload = ar;
    expect_out(name, c, b, x, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state while held in reset
    #3;
    expect_out("reset_state", 0, 0, 0, 0);
    ->mon_kick;
    @(negedge i_clk);
    i_reset_n = 1'b1;

    // Load 5, one-shot countdown
    cyc("ld5",       1, 5, 0, 0, 0, 0, 5, 0, 0, 0);
    cyc("start5",    0, 0, 1, 0, 1, 0, 5, 1, 0, 0);
    for (int k = 4; k >= 1; k--)
      cyc("run5",    0, 0, 0, 0, 1, 0, k, 1, 0, 0);
    cyc("term5",     0, 0, 0, 0, 1, 0, 0, 0, 1, 1);
    cyc("exp5_hold", 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);

    // Auto-reload with 3: done every third tick, count 2,1,3
    cyc("ld3",       1, 3, 0, 0, 0, 1, 3, 0, 0, 0);
    cyc("start3",    0, 0, 1, 0, 1, 1, 3, 1, 0, 0);
    for (int r = 0; r < 3; r++) begin
      cyc("ar_2",    0, 0, 0, 0, 1, 1, 2, 1, 0, 0);
      cyc("ar_1",    0, 0, 0, 0, 1, 1, 1, 1, 0, 0);
      cyc("ar_rld",  0, 0, 0, 0, 1, 1, 3, 1, 0, 1);
    end
    cyc("ar_stop",   0, 0, 0, 1, 1, 1, 3, 0, 0, 0);

    // Pause / resume / enable freeze
    cyc("ld10",      1, 10, 0, 0, 0, 0, 10, 0, 0, 0);
    cyc("start10",   0, 0, 1, 0, 1, 0, 10, 1, 0, 0);
    for (int k = 9; k >= 6; k--)
      cyc("run10",   0, 0, 0, 0, 1, 0, k, 1, 0, 0);
    cyc("stop6",     0, 0, 0, 1, 1, 0, 6, 0, 0, 0);
    for (int h = 0; h < 4; h++)
      cyc("hold6",   0, 0, 0, 0, 1, 0, 6, 0, 0, 0);
    cyc("resume6",   0, 0, 1, 0, 1, 0, 6, 1, 0, 0);
    cyc("run_5",     0, 0, 0, 0, 1, 0, 5, 1, 0, 0);
    cyc("run_4",     0, 0, 0, 0, 1, 0, 4, 1, 0, 0);
    for (int h = 0; h < 3; h++)
      cyc("en_low",  0, 0, 0, 0, 0, 0, 4, 1, 0, 0);
    cyc("start_in_run", 0, 0, 1, 0, 1, 0, 3, 1, 0, 0);
    cyc("stop3",     0, 0, 0, 1, 1, 0, 3, 0, 0, 0);

    // Zero load, load+start together, zero reload in EXPIRED
    cyc("ld0",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("start0",    0, 0, 1, 0, 1, 0, 0, 0, 1, 1);
    cyc("exp0_hold", 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    cyc("ld_and_st", 1, 7, 1, 0, 1, 0, 7, 0, 0, 0);
    cyc("ld7_idle",  0, 0, 0, 0, 1, 0, 7, 0, 0, 0);
    cyc("ld0b",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("start0b",   0, 0, 1, 0, 0, 0, 0, 0, 1, 1);
    cyc("restart_r0",0, 0, 1, 0, 0, 0, 0, 0, 1, 1);
    cyc("exp_r0",    0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("stop_exp",  0, 0, 0, 1, 0, 0, 0, 0, 1, 0);

    // Restart from EXPIRED with reload 4
    cyc("ld4",       1, 4, 0, 0, 0, 0, 4, 0, 0, 0);
    cyc("start4",    0, 0, 1, 0, 1, 0, 4, 1, 0, 0);
    for (int k = 3; k >= 1; k--)
      cyc("run4",    0, 0, 0, 0, 1, 0, k, 1, 0, 0);
    cyc("term4",     0, 0, 0, 0, 1, 0, 0, 0, 1, 1);
    cyc("restart4",  0, 0, 1, 0, 0, 0, 4, 1, 0, 0);
    cyc("restart4_h",0, 0, 0, 0, 0, 0, 4, 1, 0, 0);
    cyc("stop4",     0, 0, 0, 1, 0, 0, 4, 0, 0, 0);

    // Async reset mid-countdown at 150
    cyc("ld200",     1, 200, 0, 0, 0, 0, 200, 0, 0, 0);
    cyc("start200",  0, 0, 1, 0, 1, 0, 200, 1, 0, 0);
    for (int k = 199; k >= 150; k--)
      cyc("run200",  0, 0, 0, 0, 1, 0, k, 1, 0, 0);
    @(posedge i_clk);
    #3;
    i_reset_n = 1'b0;
    expect_out("async_rst", 0, 0, 0, 0);
    ->mon_kick;
    cyc("rst_hold",  0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc("rst_hold2", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    cyc("post_rst",  0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc("post_start",0, 0, 1, 0, 1, 0, 0, 0, 1, 1);

    @(negedge i_clk);
    i_start = 1'b0;
    @(negedge i_clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
